// File: rtl/pacman_life_controller.sv
// Purpose : owns Pac-Man's spare-life count and the READY / PLAY / DYING / GAME_OVER sequence.
// Latency : every output is registered and reflects inputs sampled on the previous Clk edge.
// Backpres: none; event inputs are levels or pulses that are acted on or ignored by state.
//
// Ports
//   Clk, Reset        system clock, synchronous active-high reset
//   frame_clk         vertical-sync-rate level, synchronous to Clk; its rising edge is one frame
//   start_game        level: begin a new game from IDLE or GAME_OVER
//   collision         level: lethal Pac-Man/ghost overlap, honoured in PLAY only
//   level_clear       level: all dots eaten, honoured in PLAY only
//   award_life        one-cycle pulse: extra life, honoured in READY and PLAY only
//   lives             spare lives 0..2, drives the life-icon renderer
//   freeze            1 = sprites must not move
//   dying             1 while the death animation plays
//   death_frame       death-animation sprite index (0 outside DYING)
//   respawn           one-cycle pulse on entry to READY from PLAY, DYING or GAME_OVER
//   game_over         1 while in GAME_OVER
module pacman_life_controller #(
  parameter int START_SPARES    = 2,
  parameter int READY_FRAMES    = 120,
  parameter int DEATH_FRAMES    = 90,
  parameter int DEATH_ANIM_STEP = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_game,
  input  logic       collision,
  input  logic       level_clear,
  input  logic       award_life,
  output logic [1:0] lives,
  output logic       freeze,
  output logic       dying,
  output logic [3:0] death_frame,
  output logic       respawn,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DYING     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  localparam logic [1:0] START_LIVES = 2'(START_SPARES);
  localparam logic [1:0] MAX_LIVES   = 2'd2;
  localparam logic [7:0] READY_LAST  = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] ANIM_STEP   = 8'(DEATH_ANIM_STEP);

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [1:0] lives_q, lives_d;
  logic       fsync1_q, fsync2_q;
  logic       freeze_q, freeze_d;
  logic       dying_q, dying_d;
  logic [3:0] death_frame_q, death_frame_d;
  logic       respawn_q, respawn_d;
  logic       game_over_q, game_over_d;

  logic       tick;
  logic [1:0] lives_inc;
  logic [7:0] anim_quot;

  // One Clk cycle per rising edge of the frame signal.
  assign tick = fsync1_q & ~fsync2_q;

  // An extra life never pushes the icon count past what the renderer shows.
  assign lives_inc = (lives_q >= MAX_LIVES) ? MAX_LIVES : lives_q + 2'd1;

  // ---------------------------------------------------------------
  // Process 1: state and output registers
  // ---------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      fcnt_q        <= 8'd0;
      lives_q       <= START_LIVES;
      fsync1_q      <= 1'b0;
      fsync2_q      <= 1'b0;
      freeze_q      <= 1'b1;
      dying_q       <= 1'b0;
      death_frame_q <= 4'd0;
      respawn_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      lives_q       <= lives_d;
      fsync1_q      <= frame_clk;
      fsync2_q      <= fsync1_q;
      freeze_q      <= freeze_d;
      dying_q       <= dying_d;
      death_frame_q <= death_frame_d;
      respawn_q     <= respawn_d;
      game_over_q   <= game_over_d;
    end
  end

  // ---------------------------------------------------------------
  // Process 2: next state, with the life-count and respawn actions
  // that belong to each transition
  // ---------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // No respawn here: positions are already at their start values.
        if (start_game) begin
          state_d = ST_READY;
          lives_d = START_LIVES;
        end
      end

      ST_READY: begin
        if (award_life) begin
          lives_d = lives_inc;
        end
        if (tick && (fcnt_q == READY_LAST)) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // An award coinciding with a collision still lands, so the
        // decrement at the end of DYING sees the incremented count.
        if (award_life) begin
          lives_d = lives_inc;
        end
        if (collision) begin
          state_d = ST_DYING;
        end else if (level_clear) begin
          state_d   = ST_READY;
          respawn_d = 1'b1;
        end
      end

      ST_DYING: begin
        if (tick && (fcnt_q == DEATH_LAST)) begin
          if (lives_q == 2'd0) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d   = ST_READY;
            lives_d   = lives_q - 2'd1;
            respawn_d = 1'b1;
          end
        end
      end

      ST_GAME_OVER: begin
        if (start_game) begin
          state_d   = ST_READY;
          lives_d   = START_LIVES;
          respawn_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame counter restarts on every state entry so each timed state
  // counts its own frames from zero.
  always_comb begin
    fcnt_d = fcnt_q;
    if (state_d != state_q) begin
      fcnt_d = 8'd0;
    end else if (tick) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------
  // Process 3: outputs, decoded from the next state so the registered
  // outputs line up with the state they describe
  // ---------------------------------------------------------------
  assign anim_quot = fcnt_d / ANIM_STEP;

  always_comb begin
    freeze_d      = 1'b1;
    dying_d       = 1'b0;
    death_frame_d = 4'd0;
    game_over_d   = 1'b0;

    case (state_d)
      ST_PLAY: begin
        freeze_d = 1'b0;
      end
      ST_DYING: begin
        dying_d       = 1'b1;
        death_frame_d = (anim_quot > 8'd15) ? 4'd15 : anim_quot[3:0];
      end
      ST_GAME_OVER: begin
        game_over_d = 1'b1;
      end
      default: begin
        freeze_d = 1'b1;
      end
    endcase
  end

  assign lives       = lives_q;
  assign freeze      = freeze_q;
  assign dying       = dying_q;
  assign death_frame = death_frame_q;
  assign respawn     = respawn_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_pacman_life_controller.sv
// Bench for pacman_life_controller with READY_FRAMES=4, DEATH_FRAMES=6, DEATH_ANIM_STEP=2
// and an 8-cycle frame_clk. Each table step drives its inputs for one cycle at a fixed frame
// phase, waits a whole number of frames (one tick per frame), then checks the outputs.
module tb_pacman_life_controller;

  logic       clk;
  logic       rst;
  logic       frame_clk;
  logic       start_game;
  logic       collision;
  logic       level_clear;
  logic       award_life;
  logic [1:0] lives;
  logic       freeze;
  logic       dying;
  logic [3:0] death_frame;
  logic       respawn;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_cnt = 0;
  int fcyc = 0;

  typedef struct {
    string      name;
    logic       st;
    logic       co;
    logic       lc;
    logic       aw;
    int         waitp;
    logic [1:0] e_lives;
    logic       e_freeze;
    logic       e_dying;
    logic [3:0] e_df;
    logic       e_go;
    int         e_resp;
  } vec_t;

  vec_t tbl[$];

  pacman_life_controller #(
    .START_SPARES   (2),
    .READY_FRAMES   (4),
    .DEATH_FRAMES   (6),
    .DEATH_ANIM_STEP(2)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .frame_clk  (frame_clk),
    .start_game (start_game),
    .collision  (collision),
    .level_clear(level_clear),
    .award_life (award_life),
    .lives      (lives),
    .freeze     (freeze),
    .dying      (dying),
    .death_frame(death_frame),
    .respawn    (respawn),
    .game_over  (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // frame_clk: 4 cycles low, 4 cycles high
  initial begin
    frame_clk = 1'b0;
    forever begin
      @(negedge clk);
      fcyc = (fcyc + 1) % 8;
      frame_clk = (fcyc >= 4);
    end
  end

  // counts cycles with respawn high; one-cycle pulses give one count each
  initial begin
    forever begin
      @(negedge clk);
      if (respawn === 1'b1) resp_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic add(input string n, input logic st, input logic co, input logic lc,
                     input logic aw, input int w, input logic [1:0] l, input logic fr,
                     input logic dy, input logic [3:0] df, input logic go, input int rs);
    vec_t v;
    v.name = n; v.st = st; v.co = co; v.lc = lc; v.aw = aw; v.waitp = w;
    v.e_lives = l; v.e_freeze = fr; v.e_dying = dy; v.e_df = df; v.e_go = go; v.e_resp = rs;
    tbl.push_back(v);
  endtask

  // entered and left on a negedge at the same frame phase
  task automatic run_step(input vec_t v);
    int r0;
    r0 = resp_cnt;
    start_game  = v.st;
    collision   = v.co;
    level_clear = v.lc;
    award_life  = v.aw;
    @(negedge clk);
    start_game  = 1'b0;
    collision   = 1'b0;
    level_clear = 1'b0;
    award_life  = 1'b0;
    repeat (8 * v.waitp - 1) @(negedge clk);
    chk({v.name, ".lives"},       32'(lives),       32'(v.e_lives));
    chk({v.name, ".freeze"},      32'(freeze),      32'(v.e_freeze));
    chk({v.name, ".dying"},       32'(dying),       32'(v.e_dying));
    chk({v.name, ".death_frame"}, 32'(death_frame), 32'(v.e_df));
    chk({v.name, ".game_over"},   32'(game_over),   32'(v.e_go));
    chk({v.name, ".respawn_cyc"}, 32'(resp_cnt - r0), 32'(v.e_resp));
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    start_game = 1'b0; collision = 1'b0; level_clear = 1'b0; award_life = 1'b0;

    //   name                st co lc aw  W  lives frz dy df go resp
    add("ready_hold",         1, 0, 0, 0, 3, 2'd2, 1, 0, 4'd0, 0, 0);
    add("enter_play",         0, 0, 0, 0, 1, 2'd2, 0, 0, 4'd0, 0, 0);
    add("award_at_2",         0, 0, 0, 1, 1, 2'd2, 0, 0, 4'd0, 0, 0);
    add("coll_2ticks",        0, 1, 0, 0, 2, 2'd2, 1, 1, 4'd1, 0, 0);
    add("award_in_dying",     0, 0, 0, 1, 2, 2'd2, 1, 1, 4'd2, 0, 0);
    add("death1_end",         0, 0, 0, 0, 2, 2'd1, 1, 0, 4'd0, 0, 1);
    add("coll_in_ready",      0, 1, 0, 0, 3, 2'd1, 1, 0, 4'd0, 0, 0);
    add("play_again",         0, 0, 0, 0, 1, 2'd1, 0, 0, 4'd0, 0, 0);
    add("award_at_1",         0, 0, 0, 1, 1, 2'd2, 0, 0, 4'd0, 0, 0);
    add("coll_and_clear",     0, 1, 1, 0, 1, 2'd2, 1, 1, 4'd0, 0, 0);
    add("death2_end",         0, 0, 0, 0, 5, 2'd1, 1, 0, 4'd0, 0, 1);
    add("ready_to_play",      0, 0, 0, 0, 4, 2'd1, 0, 0, 4'd0, 0, 0);
    add("level_clear",        0, 0, 1, 0, 1, 2'd1, 1, 0, 4'd0, 0, 1);
    add("clear_to_play",      0, 0, 0, 0, 3, 2'd1, 0, 0, 4'd0, 0, 0);
    add("death3",             0, 1, 0, 0, 6, 2'd0, 1, 0, 4'd0, 0, 1);
    add("play_at_0",          0, 0, 0, 0, 4, 2'd0, 0, 0, 4'd0, 0, 0);
    add("final_death",        0, 1, 0, 0, 6, 2'd0, 1, 0, 4'd0, 1, 0);
    add("coll_in_game_over",  0, 1, 0, 0, 1, 2'd0, 1, 0, 4'd0, 1, 0);
    add("restart",            1, 0, 0, 0, 1, 2'd2, 1, 0, 4'd0, 0, 1);
    add("restart_play",       0, 0, 0, 0, 3, 2'd2, 0, 0, 4'd0, 0, 0);
    add("death5",             0, 1, 0, 0, 6, 2'd1, 1, 0, 4'd0, 0, 1);
    add("play_before_reset",  0, 0, 0, 0, 4, 2'd1, 0, 0, 4'd0, 0, 0);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset.lives",       32'(lives),       32'd2);
    chk("reset.freeze",      32'(freeze),      32'd1);
    chk("reset.dying",       32'(dying),       32'd0);
    chk("reset.death_frame", 32'(death_frame), 32'd0);
    chk("reset.respawn",     32'(respawn),     32'd0);
    chk("reset.game_over",   32'(game_over),   32'd0);
    rst = 1'b0;

    // align to one cycle after a frame_clk fall
    @(negedge frame_clk);
    @(negedge clk);

    foreach (tbl[i]) run_step(tbl[i]);

    // collision latency: dying and freeze on the cycle after it is sampled
    r0 = resp_cnt;
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    chk("coll_latency.dying",       32'(dying),       32'd1);
    chk("coll_latency.freeze",      32'(freeze),      32'd1);
    chk("coll_latency.death_frame", 32'(death_frame), 32'd0);
    chk("coll_latency.lives",       32'(lives),       32'd1);

    // three ticks into DYING, then reset
    repeat (23) @(negedge clk);
    chk("dying_t3.death_frame", 32'(death_frame), 32'd1);
    chk("dying_t3.dying",       32'(dying),       32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_dying_reset.lives",       32'(lives),       32'd2);
    chk("mid_dying_reset.dying",       32'(dying),       32'd0);
    chk("mid_dying_reset.death_frame", 32'(death_frame), 32'd0);
    chk("mid_dying_reset.freeze",      32'(freeze),      32'd1);
    chk("mid_dying_reset.respawn",     32'(respawn),     32'd0);
    chk("mid_dying_reset.game_over",   32'(game_over),   32'd0);

    // stays in IDLE without start_game, no respawn
    repeat (16) @(negedge clk);
    chk("idle_hold.freeze",      32'(freeze),         32'd1);
    chk("idle_hold.lives",       32'(lives),          32'd2);
    chk("idle_hold.respawn_cyc", 32'(resp_cnt - r0),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
